hl_load_arbiter: RTL
====================

// Module: hl_load_arbiter
// PURPOSE
//  Sequencer and arbiter for one 16-bit split high/low load register (N=16, 8-bit halves).
//  Two byte-wide requesters (A, B) each deliver a word as low byte then high byte; the
//  block grants the register round-robin, drives its loadl/loadh/clear controls, holds
//  the word until the consumer takes it, and aborts a pair whose high byte stalls.
// PARAMETERS
//  TIMEOUT  16  max cycles in HI waiting for owner's high byte before abort (>=1)
// PORTS
//  clk         in   1   clock; all state on posedge
//  reset       in   1   synchronous, active-high reset
//  a_valid     in   1   requester A byte valid
//  a_byte      in   8   requester A byte
//  a_ready     out  1   A byte accepted this cycle when a_valid&a_ready
//  b_valid     in   1   requester B byte valid
//  b_byte      in   8   requester B byte
//  b_ready     out  1   B byte accepted this cycle when b_valid&b_ready
//  flush       in   1   abort any pair/word in progress
//  word_ready  in   1   consumer takes word when word_valid&word_ready
//  word_valid  out  1   register holds complete word (registered, = state FULL)
//  word_src    out  1   owner of held word: 0=A, 1=B (registered)
//  reg_inl     out  8   to register low-half data
//  reg_inh     out  8   to register high-half data
//  reg_loadl   out  1   to register low-half load
//  reg_loadh   out  1   to register high-half load
//  reg_clear   out  1   to register clear (registered pulse)
//  timeout_err out  1   one-cycle registered pulse on timeout abort
// BEHAVIOUR
//  States: IDLE, HI (low byte loaded, awaiting owner's high byte), FULL (word held).
//  Reset (sync): state=IDLE, owner=0, last_grant=1 (A wins first tie), counter=0,
//   word_valid=0, word_src=0, timeout_err=0, reg_clear=1 while reset asserted.
//  IDLE: chosen = sole valid requester; if both valid, the one != last_grant.
//   ready high for chosen only (combinational); on accept: reg_loadl=1, reg_inl=byte,
//   owner<=chosen, counter<=0, ->HI. No valid: stay, no loads.
//  HI: ready high for owner only; other requester ready=0. On owner accept: reg_loadh=1,
//   reg_inh=byte, ->FULL. Else counter++; when counter reaches TIMEOUT-1 with no accept:
//   ->IDLE, reg_clear pulse next cycle, timeout_err pulse, last_grant<=owner.
//  FULL: word_valid=1, word_src=owner, both ready=0. word_ready -> IDLE, last_grant<=owner;
//   register not cleared (contents stale but harmless). Hold indefinitely otherwise.
//  reg_loadl and reg_loadh never both 1; both 0 outside accept cycles (register holds).
//   reg_inl/reg_inh = granted byte on accept cycles, 0 otherwise.
//  Latency: high byte accepted cycle T -> word_valid=1 from T+1; consumer accept at T+1
//   allows a new low byte accept at T+2 earliest.
//  flush (priority over all): any state ->IDLE next cycle, ready=0 and no loads that cycle,
//   reg_clear=1 next cycle, no timeout_err; word in FULL is dropped even if word_ready=1.
//   last_grant<=owner if state was HI/FULL, unchanged in IDLE.
//  Timeout on same cycle as owner accept: accept wins, no abort.
//  reset mid-pair overrides flush/timeout; word lost, reg_clear held.
// TESTING
//  A sends 0x34 then 0x12 -> loadl cycle inl=0x34, loadh next accept inh=0x12, word_valid=1
//   next cycle with word_src=0; word_ready -> IDLE.
//  A and B valid together from reset -> A granted; after A's word consumed, both valid -> B
//   granted; B bytes 0xCD,0xAB -> word_src=1, b_ready=0 while A owns HI.
//  TIMEOUT=4: A sends low 0x55, goes idle -> after 4 HI cycles timeout_err and reg_clear
//   pulse 1 cycle, state IDLE, next tie grants B.
//  word_valid held 10 cycles with word_ready=0 -> no ready to A/B, no loads, word stable.
//  flush in HI and in FULL with word_ready=1 -> IDLE, reg_clear pulse, no timeout_err.
//  reset asserted in HI -> next cycle all outputs at reset values, reg_clear=1.

Source files
------------

// File: rtl/hl_load_if.sv
// Handshake and register-control bundle between two byte requesters, the
// word consumer, the split high/low load register and the load arbiter.
interface hl_load_if;
    logic       a_valid;
    logic [7:0] a_byte;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_byte;
    logic       b_ready;
    logic       flush;
    logic       word_ready;
    logic       word_valid;
    logic       word_src;
    logic [7:0] reg_inl;
    logic [7:0] reg_inh;
    logic       reg_loadl;
    logic       reg_loadh;
    logic       reg_clear;
    logic       timeout_err;

    // Requesters, consumer and register side.
    modport master (
        output a_valid, a_byte, b_valid, b_byte, flush, word_ready,
        input  a_ready, b_ready, word_valid, word_src,
        input  reg_inl, reg_inh, reg_loadl, reg_loadh, reg_clear, timeout_err
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_byte, b_valid, b_byte, flush, word_ready,
        output a_ready, b_ready, word_valid, word_src,
        output reg_inl, reg_inh, reg_loadl, reg_loadh, reg_clear, timeout_err
    );
endinterface

// File: rtl/hl_load_arbiter.sv
// Round-robin sequencer for a 16-bit split high/low load register. Each of two
// byte requesters delivers low byte then high byte; the word is held until the
// consumer takes it. A stalled high byte aborts the pair after TIMEOUT cycles.
module hl_load_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    hl_load_if.slave    bus
);

    // TIMEOUT-1 must fit in the counter.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t        state_r;
    logic          owner_r;
    logic          last_grant_r;
    logic [CW-1:0] count_r;
    logic          word_valid_r;
    logic          word_src_r;
    logic          reg_clear_r;
    logic          timeout_err_r;

    logic          chosen_s;
    logic          sel_s;
    logic          a_ready_s;
    logic          b_ready_s;
    logic          accept_s;
    logic [7:0]    acc_byte_s;
    logic          loadl_s;
    logic          loadh_s;
    logic [7:0]    inl_s;
    logic [7:0]    inh_s;

    // Grant selection: sole valid requester wins, a tie goes to the one not granted last.
    always_comb begin
        chosen_s = 1'b0;
        if (bus.a_valid && bus.b_valid) begin
            chosen_s = ~last_grant_r;
        end else if (bus.b_valid) begin
            chosen_s = 1'b1;
        end else begin
            chosen_s = 1'b0;
        end
    end

    // Ready/load decode; reset and flush suppress every handshake and load.
    always_comb begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        sel_s     = chosen_s;
        if (reset || bus.flush) begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    a_ready_s = bus.a_valid & ~chosen_s;
                    b_ready_s = bus.b_valid &  chosen_s;
                    sel_s     = chosen_s;
                end
                ST_HI: begin
                    a_ready_s = ~owner_r;
                    b_ready_s =  owner_r;
                    sel_s     =  owner_r;
                end
                default: begin
                    a_ready_s = 1'b0;
                    b_ready_s = 1'b0;
                end
            endcase
        end
        accept_s   = (bus.a_valid & a_ready_s) | (bus.b_valid & b_ready_s);
        acc_byte_s = sel_s ? bus.b_byte : bus.a_byte;
        loadl_s    = accept_s & (state_r == ST_IDLE);
        loadh_s    = accept_s & (state_r == ST_HI);
        if (loadl_s) begin
            inl_s = acc_byte_s;
        end else begin
            inl_s = 8'h00;
        end
        if (loadh_s) begin
            inh_s = acc_byte_s;
        end else begin
            inh_s = 8'h00;
        end
    end

    // Pair/word sequencing FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            count_r       <= '0;
            word_valid_r  <= 1'b0;
            word_src_r    <= 1'b0;
            reg_clear_r   <= 1'b1;
            timeout_err_r <= 1'b0;
        end else begin
            reg_clear_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            if (bus.flush) begin
                state_r      <= ST_IDLE;
                word_valid_r <= 1'b0;
                count_r      <= '0;
                reg_clear_r  <= 1'b1;
                if (state_r != ST_IDLE) begin
                    last_grant_r <= owner_r;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            owner_r <= sel_s;
                            count_r <= '0;
                            state_r <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        // An accept on the final cycle beats the abort.
                        if (accept_s) begin
                            state_r      <= ST_FULL;
                            word_valid_r <= 1'b1;
                            word_src_r   <= owner_r;
                        end else if (count_r == CNT_LAST) begin
                            state_r       <= ST_IDLE;
                            count_r       <= '0;
                            reg_clear_r   <= 1'b1;
                            timeout_err_r <= 1'b1;
                            last_grant_r  <= owner_r;
                        end else begin
                            count_r <= count_r + CNT_ONE;
                        end
                    end
                    ST_FULL: begin
                        // Register is left holding the stale word; a new pair overwrites it.
                        if (bus.word_ready) begin
                            state_r      <= ST_IDLE;
                            word_valid_r <= 1'b0;
                            last_grant_r <= owner_r;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        word_valid_r <= 1'b0;
                        count_r      <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.a_ready     = a_ready_s;
    assign bus.b_ready     = b_ready_s;
    assign bus.reg_loadl   = loadl_s;
    assign bus.reg_loadh   = loadh_s;
    assign bus.reg_inl     = inl_s;
    assign bus.reg_inh     = inh_s;
    assign bus.word_valid  = word_valid_r;
    assign bus.word_src    = word_src_r;
    assign bus.reg_clear   = reg_clear_r;
    assign bus.timeout_err = timeout_err_r;

endmodule
